// File: rtl/uart_core_cfg.sv
// uart_core_cfg: full-duplex UART core with a runtime baud divisor, parity,
// 1/2 TX stop bits, and a 16x oversampled receiver with error flags.
// Optional build macro UART_RX_FIFO_EN swaps the single RX holding register
// for an RX_FIFO_DEPTH-entry show-ahead FIFO of {ferr, perr, data}.
module uart_core_cfg #(
    parameter int DATA_BITS     = 8,
    parameter int DIV_W         = 16,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    input  logic                 rx_err_clr,
    output logic                 rx_idle
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [7:0] IDLE_TICKS = 8'd160;

    // Parity bit for a word: even -> XOR of data, odd -> its complement.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Saturating increment used by the line-idle counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= IDLE_TICKS) ? IDLE_TICKS : v + 8'd1;
    endfunction

    // ---------------------------------------------------------------- tick gen
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    // Down-counter; reload picks up a new baud_div only when it expires.
    always_comb begin
        tick      = (div_cnt_q == '0);
        div_cnt_d = tick ? baud_div : div_cnt_q - 1'b1;
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    // ---------------------------------------------------------------- transmitter
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;

    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_par_en_q, tx_par_en_d;
    logic                 tx_stop2_q, tx_stop2_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 txd_q, txd_d;
    logic                 tx_end;

    // TX next state; frame options are frozen at the handshake.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_stop2_d  = tx_stop2_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_end      = tick && (tx_tick_q == 4'hF);
        if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_shift_d  = tx_data;
                    tx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    tx_par_d    = calc_parity(tx_data, parity_mode == 2'b10);
                    tx_stop2_d  = stop2;
                    tx_tick_d   = 4'd0;
                    tx_bit_d    = '0;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: if (tx_end) tx_state_d = TX_DATA;
            TX_DATA: begin
                if (tx_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == LAST_BIT) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
                    else                      tx_bit_d   = tx_bit_q + 1'b1;
                end
            end
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP1;
            TX_STOP1:  if (tx_end) tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (tx_end) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
        // txd is registered from the next state so it changes with the state.
        case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_d[0];
            TX_PARITY: txd_d = tx_par_q;
            default:   txd_d = 1'b1;
        endcase
    end

    // TX registers; txd forced high asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_tick_q   <= 4'd0;
            tx_bit_q    <= '0;
            txd_q       <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_par_en_q <= tx_par_en_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            txd_q       <= txd_d;
        end
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign txd      = txd_q;

    // ---------------------------------------------------------------- receiver
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic                 rx_s1_q, rx_s2_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_arm_q, rx_arm_d;
    logic [3:0]           rx_ph_q, rx_ph_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d;
    logic                 rx_par_odd_q, rx_par_odd_d;
    logic                 rx_perr_acc_q, rx_perr_acc_d;
    logic [7:0]           idle_cnt_q, idle_cnt_d;
    logic                 rx_sync;
    logic                 rx_done;
    logic                 rx_done_ferr;

    assign rx_sync = rx_s2_q;

    // RX next state; START checked half a bit in, later bits every 16 ticks.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_arm_d      = rx_arm_q;
        rx_ph_d       = rx_ph_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_par_en_d   = rx_par_en_q;
        rx_par_odd_d  = rx_par_odd_q;
        rx_perr_acc_d = rx_perr_acc_q;
        rx_done       = 1'b0;
        rx_done_ferr  = 1'b0;
        if (rx_state_q != RX_IDLE && tick) rx_ph_d = rx_ph_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                // After a break the line must return high before re-arming.
                if (!rx_arm_q && rx_sync) rx_arm_d = 1'b1;
                if (rx_arm_q && !rx_sync) begin
                    rx_state_d    = RX_START;
                    rx_ph_d       = 4'd0;
                    rx_bit_d      = '0;
                    rx_par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    rx_par_odd_d  = (parity_mode == 2'b10);
                    rx_perr_acc_d = 1'b0;
                end
            end
            RX_START: begin
                if (tick && rx_ph_q == 4'd7) begin
                    rx_ph_d    = 4'd0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && rx_ph_q == 4'hF) begin
                    rx_ph_d    = 4'd0;
                    rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (tick && rx_ph_q == 4'hF) begin
                    rx_ph_d       = 4'd0;
                    rx_perr_acc_d = (rx_sync != calc_parity(rx_shift_q, rx_par_odd_q));
                    rx_state_d    = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && rx_ph_q == 4'hF) begin
                    rx_ph_d      = 4'd0;
                    rx_done      = 1'b1;
                    rx_done_ferr = !rx_sync;
                    rx_state_d   = RX_IDLE;
                    if (!rx_sync) rx_arm_d = 1'b0;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // Line-idle timer only runs while the receiver sits idle on a high line.
        if (rx_state_q != RX_IDLE || !rx_sync) idle_cnt_d = 8'd0;
        else if (tick)                         idle_cnt_d = sat_inc(idle_cnt_q);
        else                                   idle_cnt_d = idle_cnt_q;
    end

    // RX synchroniser, FSM and idle timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_arm_q      <= 1'b1;
            rx_ph_q       <= 4'd0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_perr_acc_q <= 1'b0;
            idle_cnt_q    <= 8'd0;
        end else begin
            rx_s1_q       <= rxd;
            rx_s2_q       <= rx_s1_q;
            rx_state_q    <= rx_state_d;
            rx_arm_q      <= rx_arm_d;
            rx_ph_q       <= rx_ph_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_en_q   <= rx_par_en_d;
            rx_par_odd_q  <= rx_par_odd_d;
            rx_perr_acc_q <= rx_perr_acc_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign rx_idle = (idle_cnt_q == IDLE_TICKS);

    // ---------------------------------------------------------------- delivery
    logic rx_ovr_q, rx_ovr_d;
    logic rx_drop;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [DATA_BITS+1:0] rx_mem_q [RX_FIFO_DEPTH];
    logic [DATA_BITS+1:0] rx_mem_d [RX_FIFO_DEPTH];
    logic [AW:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic                 fifo_empty, fifo_full, fifo_push, fifo_pop;

    // FIFO pointers/storage; a push into a full FIFO is legal when it also pops.
    always_comb begin
        fifo_empty = (rx_wr_q == rx_rd_q);
        fifo_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
        fifo_pop   = !fifo_empty && rx_ready;
        fifo_push  = rx_done && (!fifo_full || fifo_pop);
        rx_drop    = rx_done && fifo_full && !fifo_pop;
        rx_mem_d   = rx_mem_q;
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        if (fifo_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = {rx_done_ferr, rx_perr_acc_q, rx_shift_q};
            rx_wr_d = rx_wr_q + 1'b1;
        end
        if (fifo_pop) rx_rd_d = rx_rd_q + 1'b1;
        rx_ovr_d = rx_drop ? 1'b1 : (rx_err_clr ? 1'b0 : rx_ovr_q);
    end

    // FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_ovr_q <= 1'b0;
        end else begin
            rx_mem_q <= rx_mem_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_ovr_q <= rx_ovr_d;
        end
    end

    assign rx_valid = !fifo_empty;
    assign rx_data  = rx_mem_q[rx_rd_q[AW-1:0]][DATA_BITS-1:0];
    assign rx_perr  = rx_mem_q[rx_rd_q[AW-1:0]][DATA_BITS];
    assign rx_ferr  = rx_mem_q[rx_rd_q[AW-1:0]][DATA_BITS+1];
`else
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_pop;

    // Holding register: load when empty or being emptied, else drop and flag.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = rx_valid_q;
        rx_drop    = 1'b0;
        rx_pop     = rx_valid_q && rx_ready;
        if (rx_pop) rx_valid_d = 1'b0;
        if (rx_done) begin
            if (!rx_valid_q || rx_pop) begin
                rx_data_d  = rx_shift_q;
                rx_perr_d  = rx_perr_acc_q;
                rx_ferr_d  = rx_done_ferr;
                rx_valid_d = 1'b1;
            end else begin
                rx_drop = 1'b1;
            end
        end
        rx_ovr_d = rx_drop ? 1'b1 : (rx_err_clr ? 1'b0 : rx_ovr_q);
    end

    // Holding register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_perr  = rx_perr_q;
    assign rx_ferr  = rx_ferr_q;
`endif

    assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg at baud_div=0 (one bit = 16 clocks).
// TX frames come from a table of hand-computed line patterns and loop back
// into RX; RX corner cases are driven directly on rxd.
module tb_uart_core_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [15:0] baud_div;
    logic [1:0] parity_mode;
    logic       stop2;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       rxd_drv;
    logic       lb;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid, rx_ready, rx_overrun, rx_err_clr, rx_idle;

    int nchk  = 0;
    int nfail = 0;

    assign rxd = lb ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_core_cfg #(.DATA_BITS(8), .DIV_W(16), .RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
        .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .rx_err_clr(rx_err_clr), .rx_idle(rx_idle)
    );

    // frame: bit i is the line level during bit time i (bit 0 = start bit)
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        stop2;
        int          nbits;
        logic [11:0] frame;
    } tx_vec_t;

    tx_vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic send_tx(input tx_vec_t v, input bit check_rx);
        int n = 0;
        while (!tx_ready && n < 400) begin
            cyc(1);
            n++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        parity_mode = v.pmode;
        stop2       = v.stop2;
        tx_data     = v.data;
        tx_valid    = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        cyc(8);
        for (int i = 0; i < v.nbits; i++) begin
            chk($sformatf("txd_%0h_bit%0d", v.data, i), txd, v.frame[i]);
            if (i == v.nbits - 1) chk("tx_ready_busy", tx_ready, 0);
            cyc((i == v.nbits - 1) ? 8 : 16);
        end
        chk("tx_ready_after", tx_ready, 1);
        chk("txd_idle_after", txd, 1);
        if (check_rx) begin
            chk("lb_rx_valid", rx_valid, 1);
            chk("lb_rx_data", rx_data, v.data);
            chk("lb_rx_perr", rx_perr, 0);
            chk("lb_rx_ferr", rx_ferr, 0);
            pop_rx();
            chk("lb_rx_popped", rx_valid, 0);
        end
    endtask

    task automatic send_rx(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd_drv = bits[i];
            cyc(16);
        end
        rxd_drv = 1'b1;
    endtask

    initial begin
        tx_vec_t v12;
        logic [7:0] fifo_exp [4];
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 10, 12'h34A};
        vecs[1] = '{8'h00, 2'b01, 1'b1, 12, 12'hC00};
        vecs[2] = '{8'hFF, 2'b01, 1'b1, 12, 12'hDFE};
        vecs[3] = '{8'h3C, 2'b01, 1'b1, 12, 12'hC78};
        vecs[4] = '{8'h01, 2'b10, 1'b0, 11, 12'h402};
        vecs[5] = '{8'h80, 2'b10, 1'b1, 12, 12'hD00};
        vecs[6] = '{8'hFF, 2'b01, 1'b0, 11, 12'h5FE};
        vecs[7] = '{8'h5A, 2'b11, 1'b0, 10, 12'h2B4};
        v12     = '{8'h12, 2'b00, 1'b0, 10, 12'h224};
        fifo_exp[0] = 8'h11; fifo_exp[1] = 8'h22; fifo_exp[2] = 8'h44; fifo_exp[3] = 8'h88;

        rst_n = 1'b0; baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rxd_drv = 1'b1; lb = 1'b1;
        rx_ready = 1'b0; rx_err_clr = 1'b0;
        cyc(3);
        chk("rst_txd", txd, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_perr", rx_perr, 0);
        chk("rst_rx_ferr", rx_ferr, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_rx_idle", rx_idle, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(200);
        chk("rx_idle_after_quiet", rx_idle, 1);

        // TX patterns looped back into RX
        for (int k = 0; k < 8; k++) send_tx(vecs[k], 1'b1);

        // odd parity, parity bit wrong
        lb = 1'b0;
        parity_mode = 2'b10;
        cyc(4);
        send_rx(12'h4AA, 11);
        chk("perr_valid", rx_valid, 1);
        chk("perr_data", rx_data, 8'h55);
        chk("perr_flag", rx_perr, 1);
        chk("perr_ferr", rx_ferr, 0);
        pop_rx();

        // short low pulse is rejected, next frame still received
        parity_mode = 2'b00;
        cyc(20);
        rxd_drv = 1'b0;
        cyc(4);
        rxd_drv = 1'b1;
        cyc(40);
        chk("glitch_no_valid", rx_valid, 0);
        send_rx(12'h34A, 10);
        chk("glitch_next_valid", rx_valid, 1);
        chk("glitch_next_data", rx_data, 8'hA5);
        chk("glitch_next_ferr", rx_ferr, 0);
        pop_rx();

        // break: 12 bit times low -> one word 0x00 with framing error
        cyc(20);
        rxd_drv = 1'b0;
        cyc(96);
        chk("break_rx_idle", rx_idle, 0);
        cyc(96);
        chk("break_valid", rx_valid, 1);
        chk("break_data", rx_data, 8'h00);
        chk("break_ferr", rx_ferr, 1);
        chk("break_perr", rx_perr, 0);
        pop_rx();
        rxd_drv = 1'b1;
        cyc(80);
        chk("break_single_word", rx_valid, 0);

        // overrun with consumer stalled
`ifdef UART_RX_FIFO_EN
        send_rx(12'h222, 10);
        send_rx(12'h244, 10);
        send_rx(12'h288, 10);
        send_rx(12'h310, 10);
        chk("fifo_full_no_ovr", rx_overrun, 0);
        send_rx(12'h21E, 10);
        chk("fifo_overrun", rx_overrun, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fifo_valid%0d", k), rx_valid, 1);
            chk($sformatf("fifo_data%0d", k), rx_data, fifo_exp[k]);
            pop_rx();
        end
        chk("fifo_empty", rx_valid, 0);
`else
        send_rx(12'h222, 10);
        chk("hold_no_ovr", rx_overrun, 0);
        send_rx(12'h244, 10);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_first_kept", rx_data, fifo_exp[0]);
        chk("ovr_flag", rx_overrun, 1);
        pop_rx();
        chk("ovr_popped", rx_valid, 0);
`endif
        rx_err_clr = 1'b1;
        cyc(1);
        rx_err_clr = 1'b0;
        chk("ovr_cleared", rx_overrun, 0);

        // reset in the middle of data bit 3 of 0xA5 (line low there)
        parity_mode = 2'b00;
        stop2 = 1'b0;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        cyc(8 + 16 * 4);
        chk("midrst_txd_before", txd, 0);
        chk("midrst_busy_before", tx_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_tx_ready", tx_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        cyc(2);
        send_tx(v12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
